approx_adder_sweep_checker: RTL and testbench
=============================================

APPROX_ADDER_SWEEP_CHECKER -- requirements
Module: approx_adder_sweep_checker

Interface
REQ-001 Parameter ET, default 6, error threshold; a vector violates when its absolute error exceeds ET.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  sweep request, sampled on the rising edge of clk.
REQ-005 abort  input  1  sweep cancel, sampled on the rising edge of clk.
REQ-006 dut_in  output  8  operand vector to the 4-bit approximate adder; bits [3:0] = operand A (in0..in3), bits [7:4] = operand B (in4..in7).
REQ-007 dut_out  input  5  approximate sum {out4..out0}, combinational from dut_in in the same cycle.
REQ-008 busy  output  1  sweep in progress (SWEEP or DRAIN).
REQ-009 done  output  1  sweep complete; statistics are final.
REQ-010 pass  output  1  done and viol_cnt == 0.
REQ-011 viol_cnt  output  9  number of violating vectors, 0..256.
REQ-012 max_err  output  5  largest absolute error seen.
REQ-013 err_sum  output  13  sum of absolute errors, maximum 7936.
REQ-014 first_fail  output  8  dut_in value of the first violating vector.
REQ-015 first_fail_vld  output  1  first_fail holds a captured value.

Function
REQ-016 The FSM SHALL have exactly four states, IDLE, SWEEP, DRAIN and DONE, with IDLE as the reset state.
REQ-017 In IDLE or DONE, start=1 and abort=0 SHALL cause a transition to SWEEP, clear all statistics and first_fail_vld, reset the vector counter to 0, and deassert done.
REQ-018 start SHALL be ignored in SWEEP and DRAIN.
REQ-019 In SWEEP, dut_in SHALL equal the vector counter, which increments by 1 per cycle, so vector k is presented in the k-th SWEEP cycle (k = 0..255).
REQ-020 In IDLE, DONE and DRAIN, dut_in SHALL be 8'h00.
REQ-021 After presenting vector 255 the FSM SHALL enter DRAIN for exactly one cycle and then enter DONE; the counter SHALL not wrap back to 0 within a sweep.
REQ-022 Stage 1 SHALL register {dut_in, dut_out} together with a valid bit at the end of each SWEEP cycle.
REQ-023 Stage 2 SHALL compute exact = A + B (5-bit, no overflow) and err = |exact - dut_out| (5-bit unsigned), then update the statistics on the following edge.
REQ-024 Each stage-2 vector SHALL add err to err_sum, set max_err = max(max_err, err), and, if err > ET, increment viol_cnt.
REQ-025 On the first violation only, stage 2 SHALL capture first_fail and set first_fail_vld.
REQ-026 Timing: with start sampled at edge E0, busy SHALL be 1 from E0 until edge E0+257, at which edge busy SHALL fall and done SHALL rise, with all 256 vectors accounted for.
REQ-027 done, pass and the statistics SHALL hold in DONE until the next accepted start or reset.
REQ-028 pass SHALL be 0 whenever done is 0.
REQ-029 abort=1 in any state SHALL force IDLE on the next edge, clear the stage-1 valid bit, leave done at 0 and freeze the statistics at their partial values.
REQ-030 When start and abort are asserted together, abort SHALL take priority.
REQ-031 Counters SHALL not saturate-wrap: viol_cnt and err_sum widths cover the worst case, 256 violations and 256 × 31.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for a clock edge, force IDLE and drive all outputs and internal registers to 0, including dut_in, busy, done, pass, viol_cnt, max_err, err_sum, first_fail, first_fail_vld and the stage-1 valid bit.
REQ-033 Reset SHALL take precedence over start and abort, including when it is asserted mid-sweep.

Verification
REQ-034 Exact model, dut_out = A+B -> done at E0+257, viol_cnt=0, max_err=0, err_sum=0, pass=1, first_fail_vld=0.
REQ-035 dut_out stuck at 0 -> viol_cnt=228, max_err=30, err_sum=3840, first_fail=8'h07, first_fail_vld=1, pass=0.
REQ-036 dut_out = (A+B) XOR 5'b00001 -> err=1 for every vector, err_sum=256, max_err=1, viol_cnt=0, pass=1.
REQ-037 abort after 100 SWEEP cycles -> IDLE next edge, busy=0, done=0, dut_in=0; then start -> full clean sweep matching REQ-034.
REQ-038 rst asserted mid-sweep, between clock edges -> all outputs 0 immediately; start pulsed during SWEEP -> ignored, result unchanged.
REQ-039 start in DONE -> statistics cleared, done falls at the accepting edge, and a new sweep completes 257 edges later.

Source files
------------

// File: rtl/approx_adder_sweep_checker_if.sv
// Bundles the sweep request/cancel controls, the approximate-adder operand and
// sum path, and the status/statistics outputs of approx_adder_sweep_checker.
//   slave  : the checker (takes start/abort/dut_out, drives everything else)
//   master : the environment (drives start/abort and the adder sum)
interface approx_adder_sweep_checker_if;
  logic        start;
  logic        abort;
  logic [7:0]  dut_in;          // {B[3:0], A[3:0]}
  logic [4:0]  dut_out;         // approximate A+B, combinational from dut_in
  logic        busy;
  logic        done;
  logic        pass;
  logic [8:0]  viol_cnt;
  logic [4:0]  max_err;
  logic [12:0] err_sum;
  logic [7:0]  first_fail;
  logic        first_fail_vld;

  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, viol_cnt, max_err, err_sum,
           first_fail, first_fail_vld
  );

  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, viol_cnt, max_err, err_sum,
           first_fail, first_fail_vld
  );
endinterface

// File: rtl/approx_adder_sweep_checker.sv
// Exhaustive checker for a 4-bit approximate adder. A sweep walks all 256
// operand pairs on dut_in, registers each {operand, sum} pair, and in a
// second stage accumulates absolute-error statistics against the exact sum.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset, clears everything immediately
//   bus  - approx_adder_sweep_checker_if.slave (controls, adder path, stats)
// Parameter:
//   ET   - error threshold; a vector violates when |err| > ET
module approx_adder_sweep_checker #(
  parameter int ET = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  approx_adder_sweep_checker_if.slave   bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [4:0] ET_L  = 5'(ET);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        accept;

  // stage 1
  logic        s1_vld;
  logic [7:0]  s1_in;
  logic [4:0]  s1_out;

  // stage 2
  logic [4:0]  exact;
  logic [4:0]  err;

  logic [8:0]  viol_cnt;
  logic [4:0]  max_err;
  logic [12:0] err_sum;
  logic [7:0]  first_fail;
  logic        first_fail_vld;

  // abort outranks start everywhere
  assign accept = bus.start && !bus.abort && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (accept) begin
          state <= SWEEP;
          cnt   <= '0;
        end
        // hold at 255 rather than wrap; DRAIN lets the last vector retire
        SWEEP: if (cnt == 8'hff) state <= DRAIN;
               else              cnt   <= cnt + 8'd1;
        DRAIN: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_in  <= '0;
      s1_out <= '0;
    end else begin
      s1_vld <= (state == SWEEP) && !bus.abort;
      s1_in  <= bus.dut_in;
      s1_out <= bus.dut_out;
    end
  end

  assign exact = {1'b0, s1_in[3:0]} + {1'b0, s1_in[7:4]};
  assign err   = (exact >= s1_out) ? (exact - s1_out) : (s1_out - exact);

  // A vector already in stage 1 when abort arrives still retires; nothing
  // new enters afterwards, so the statistics freeze at that point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_cnt       <= '0;
      max_err        <= '0;
      err_sum        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else if (accept) begin
      viol_cnt       <= '0;
      max_err        <= '0;
      err_sum        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else if (s1_vld) begin
      err_sum <= err_sum + {8'd0, err};
      if (err > max_err) max_err <= err;
      if (err > ET_L) begin
        viol_cnt <= viol_cnt + 9'd1;
        if (!first_fail_vld) begin
          first_fail     <= s1_in;
          first_fail_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.dut_in         = (state == SWEEP) ? cnt : 8'h00;
  assign bus.busy           = (state == SWEEP) || (state == DRAIN);
  assign bus.done           = (state == DONE);
  assign bus.pass           = (state == DONE) && (viol_cnt == 9'd0);
  assign bus.viol_cnt       = viol_cnt;
  assign bus.max_err        = max_err;
  assign bus.err_sum        = err_sum;
  assign bus.first_fail     = first_fail;
  assign bus.first_fail_vld = first_fail_vld;
endmodule

// File: tb/tb_approx_adder_sweep_checker.sv
module tb_approx_adder_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;   // 0 exact, 1 stuck-at-0, 2 exact xor 1

  approx_adder_sweep_checker_if bus ();

  approx_adder_sweep_checker #(.ET(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [4:0] exact_sum;
  assign exact_sum   = {1'b0, bus.dut_in[3:0]} + {1'b0, bus.dut_in[7:4]};
  assign bus.dut_out = (mode == 1) ? 5'd0 :
                       (mode == 2) ? (exact_sum ^ 5'b00001) : exact_sum;

  // Starts a sweep, optionally pulses start again pulse_at edges after E0,
  // and reports the edge (relative to E0) at which done rose, plus whether
  // the presented vector sequence and busy/done levels looked right.
  task automatic run_sweep(input int pulse_at, output int done_edge, output bit seq_ok);
    int edges;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    edges  = 0;
    seq_ok = 1'b1;
    if (bus.viol_cnt !== 9'd0 || bus.err_sum !== 13'd0 || bus.first_fail_vld !== 1'b0)
      seq_ok = 1'b0;
    while (edges < 400) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.pass !== 1'b0) seq_ok = 1'b0;
      if (edges < 256 && bus.dut_in !== 8'(edges)) seq_ok = 1'b0;
      if (edges == 256 && bus.dut_in !== 8'h00) seq_ok = 1'b0;
      @(posedge clk);
      edges++;
      #1 bus.start = (edges == pulse_at);
      if (bus.done === 1'b1) break;
    end
    bus.start = 1'b0;
    if (bus.busy !== 1'b0 || bus.dut_in !== 8'h00) seq_ok = 1'b0;
    done_edge = edges;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.busy !== 0 || bus.done !== 0 || bus.pass !== 0 || bus.dut_in !== 0) begin
      errors++;
      $display("FAIL reset_ctl busy=%b done=%b pass=%b dut_in=%h want all 0",
               bus.busy, bus.done, bus.pass, bus.dut_in);
    end
    checks++;
    if (bus.viol_cnt !== 0 || bus.max_err !== 0 || bus.err_sum !== 0 ||
        bus.first_fail !== 0 || bus.first_fail_vld !== 0) begin
      errors++;
      $display("FAIL reset_stats viol=%0d max=%0d sum=%0d ff=%h ffv=%b want all 0",
               bus.viol_cnt, bus.max_err, bus.err_sum, bus.first_fail, bus.first_fail_vld);
    end
    @(negedge clk) rst = 1'b0;
    // start together with abort: abort wins, stays idle
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.dut_in !== 8'h00) begin
      errors++;
      $display("FAIL start_abort_prio busy=%b dut_in=%h want 0/00", bus.busy, bus.dut_in);
    end
  endtask

  task automatic test_exact();
    int de; bit ok;
    mode = 0;
    run_sweep(-1, de, ok);
    checks++;
    if (de !== 257) begin errors++; $display("FAIL exact_latency got %0d want 257", de); end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL exact_sequence got %b want 1", ok); end
    checks++;
    if (bus.viol_cnt !== 0 || bus.max_err !== 0 || bus.err_sum !== 0 ||
        bus.pass !== 1 || bus.done !== 1 || bus.first_fail_vld !== 0) begin
      errors++;
      $display("FAIL exact_stats viol=%0d max=%0d sum=%0d pass=%b done=%b ffv=%b want 0/0/0/1/1/0",
               bus.viol_cnt, bus.max_err, bus.err_sum, bus.pass, bus.done, bus.first_fail_vld);
    end
  endtask

  task automatic test_stuck_zero();
    int de; bit ok;
    mode = 1;
    run_sweep(-1, de, ok);
    checks++;
    if (de !== 257 || ok !== 1'b1) begin
      errors++; $display("FAIL stuck_timing edge=%0d seq=%b want 257/1", de, ok);
    end
    checks++;
    if (bus.viol_cnt !== 9'd228 || bus.max_err !== 5'd30 || bus.err_sum !== 13'd3840) begin
      errors++;
      $display("FAIL stuck_stats viol=%0d max=%0d sum=%0d want 228/30/3840",
               bus.viol_cnt, bus.max_err, bus.err_sum);
    end
    checks++;
    if (bus.first_fail !== 8'h07 || bus.first_fail_vld !== 1 || bus.pass !== 0 || bus.done !== 1) begin
      errors++;
      $display("FAIL stuck_first ff=%h ffv=%b pass=%b done=%b want 07/1/0/1",
               bus.first_fail, bus.first_fail_vld, bus.pass, bus.done);
    end
    // results hold in DONE
    repeat (5) @(negedge clk);
    checks++;
    if (bus.done !== 1 || bus.viol_cnt !== 9'd228 || bus.err_sum !== 13'd3840) begin
      errors++;
      $display("FAIL done_hold done=%b viol=%0d sum=%0d want 1/228/3840",
               bus.done, bus.viol_cnt, bus.err_sum);
    end
  endtask

  // starts from DONE with stuck-at-0 results; run_sweep checks the clear
  task automatic test_xor_one();
    int de; bit ok;
    mode = 2;
    run_sweep(-1, de, ok);
    checks++;
    if (de !== 257 || ok !== 1'b1) begin
      errors++; $display("FAIL restart_from_done edge=%0d seq=%b want 257/1", de, ok);
    end
    checks++;
    if (bus.err_sum !== 13'd256 || bus.max_err !== 5'd1 || bus.viol_cnt !== 0 ||
        bus.pass !== 1 || bus.first_fail_vld !== 0) begin
      errors++;
      $display("FAIL xor_stats sum=%0d max=%0d viol=%0d pass=%b ffv=%b want 256/1/0/1/0",
               bus.err_sum, bus.max_err, bus.viol_cnt, bus.pass, bus.first_fail_vld);
    end
  endtask

  task automatic test_abort();
    int de; bit ok;
    mode = 1;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (99) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 0 || bus.done !== 0 || bus.dut_in !== 8'h00 || bus.pass !== 0) begin
      errors++;
      $display("FAIL abort_idle busy=%b done=%b dut_in=%h pass=%b want 0/0/00/0",
               bus.busy, bus.done, bus.dut_in, bus.pass);
    end
    checks++;
    if (bus.viol_cnt === 9'd0) begin
      errors++; $display("FAIL abort_partial viol=%0d want nonzero", bus.viol_cnt);
    end
    repeat (3) @(negedge clk);
    mode = 0;
    run_sweep(-1, de, ok);
    checks++;
    if (de !== 257 || ok !== 1'b1 || bus.viol_cnt !== 0 || bus.err_sum !== 0 || bus.pass !== 1) begin
      errors++;
      $display("FAIL abort_resweep edge=%0d seq=%b viol=%0d sum=%0d pass=%b want 257/1/0/0/1",
               de, ok, bus.viol_cnt, bus.err_sum, bus.pass);
    end
  endtask

  task automatic test_rst_mid_and_start_pulse();
    int de; bit ok;
    mode = 1;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 0 || bus.done !== 0 || bus.pass !== 0 || bus.dut_in !== 0 ||
        bus.viol_cnt !== 0 || bus.max_err !== 0 || bus.err_sum !== 0 ||
        bus.first_fail !== 0 || bus.first_fail_vld !== 0) begin
      errors++;
      $display("FAIL rst_mid busy=%b done=%b dut_in=%h viol=%0d max=%0d sum=%0d ff=%h ffv=%b want all 0",
               bus.busy, bus.done, bus.dut_in, bus.viol_cnt, bus.max_err, bus.err_sum,
               bus.first_fail, bus.first_fail_vld);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    run_sweep(30, de, ok);
    checks++;
    if (de !== 257 || ok !== 1'b1) begin
      errors++; $display("FAIL start_ignored edge=%0d seq=%b want 257/1", de, ok);
    end
    checks++;
    if (bus.viol_cnt !== 9'd228 || bus.err_sum !== 13'd3840 || bus.first_fail !== 8'h07) begin
      errors++;
      $display("FAIL start_ignored_stats viol=%0d sum=%0d ff=%h want 228/3840/07",
               bus.viol_cnt, bus.err_sum, bus.first_fail);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_exact();
    test_stuck_zero();
    test_xor_one();
    test_abort();
    test_rst_mid_and_start_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
